// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_pkg
//  Description : Scan-code constants, FSM state type and digit lookup for the
//                PS/2 digit/cursor controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_kbd_pkg;

    localparam logic [7:0] c_sc_e0     = 8'hE0;
    localparam logic [7:0] c_sc_e1     = 8'hE1;
    localparam logic [7:0] c_sc_f0     = 8'hF0;
    localparam logic [7:0] c_sc_esc    = 8'h76;
    localparam logic [7:0] c_sc_up     = 8'h75;
    localparam logic [7:0] c_sc_down   = 8'h72;
    localparam logic [7:0] c_sc_left   = 8'h6B;
    localparam logic [7:0] c_sc_right  = 8'h74;
    localparam logic [7:0] c_sc_ack    = 8'hFA;
    localparam logic [7:0] c_sc_resend = 8'hFE;
    localparam logic [7:0] c_sc_bat    = 8'hAA;
    localparam logic [7:0] c_sc_echo   = 8'hEE;

    // Bytes still to swallow after the leading E1 of a Pause sequence.
    localparam logic [2:0] c_pause_len = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Returns {valid, digit} for number-row and keypad make codes.
    function automatic logic [4:0] digit_lookup(input logic [7:0] code);
        case (code)
            8'h45, 8'h70: digit_lookup = {1'b1, 4'd0};
            8'h16, 8'h69: digit_lookup = {1'b1, 4'd1};
            8'h1E, 8'h72: digit_lookup = {1'b1, 4'd2};
            8'h26, 8'h7A: digit_lookup = {1'b1, 4'd3};
            8'h25, 8'h6B: digit_lookup = {1'b1, 4'd4};
            8'h2E, 8'h73: digit_lookup = {1'b1, 4'd5};
            8'h36, 8'h74: digit_lookup = {1'b1, 4'd6};
            8'h3D, 8'h6C: digit_lookup = {1'b1, 4'd7};
            8'h3E, 8'h75: digit_lookup = {1'b1, 4'd8};
            8'h46, 8'h7D: digit_lookup = {1'b1, 4'd9};
            default:      digit_lookup = 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_digit_cursor_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_digit_cursor_ctrl_if
//  Description : Scan-byte strobe bus from the PS/2 byte receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_digit_cursor_ctrl_if;
    logic [7:0] iscan_code;
    logic       iscan_valid;

    modport master (output iscan_code, output iscan_valid);
    modport slave  (input  iscan_code, input  iscan_valid);
endinterface
`default_nettype wire

// File: rtl/ps2_scan_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_decode
//  Description : Combinational classifier of a scan byte, given whether an
//                E0 prefix is pending, into digit / arrow / Esc actions.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_decode
    import ps2_kbd_pkg::*;
(
    input  wire logic       i_ext,
    input  wire logic [7:0] i_code,
    output logic            o_is_digit,
    output logic [3:0]      o_digit,
    output logic            o_is_arrow,
    output dir_t            o_dir,
    output logic            o_is_esc
);

    logic [4:0] w_lut;

    always_comb begin
        w_lut      = digit_lookup(i_code);
        o_is_digit = ~i_ext & w_lut[4];
        o_digit    = w_lut[3:0];
        o_is_esc   = ~i_ext & (i_code == c_sc_esc);
        o_is_arrow = 1'b0;
        o_dir      = DIR_UP;
        // Arrow codes collide with keypad digits; only the E0 prefix tells them apart.
        if (i_ext) begin
            case (i_code)
                c_sc_up:    begin o_is_arrow = 1'b1; o_dir = DIR_UP;    end
                c_sc_down:  begin o_is_arrow = 1'b1; o_dir = DIR_DOWN;  end
                c_sc_left:  begin o_is_arrow = 1'b1; o_dir = DIR_LEFT;  end
                c_sc_right: begin o_is_arrow = 1'b1; o_dir = DIR_RIGHT; end
                default:    ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_digit_cursor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_digit_cursor_ctrl
//  Description : PS/2 set-2 byte stream to displayed digit and cursor cell,
//                with prefix tracking, Pause skipping and prefix timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_digit_cursor_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int CELL_W      = 40,
    parameter int CELL_H      = 40,
    parameter int ORIGIN_X    = 0,
    parameter int ORIGIN_Y    = 0,
    parameter int MAX_X       = 600,
    parameter int MAX_Y       = 440,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  wire logic              iCLK,
    input  wire logic              iRST,
    ps2_digit_cursor_ctrl_if.slave scan,
    output logic [7:0]             oascii,
    output logic [9:0]             ocur_x,
    output logic [9:0]             ocur_y,
    output logic                   okey_evt
);

    localparam int              c_to_w     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);
    localparam logic [9:0]      c_cell_w   = 10'(CELL_W);
    localparam logic [9:0]      c_cell_h   = 10'(CELL_H);
    localparam logic [9:0]      c_origin_x = 10'(ORIGIN_X);
    localparam logic [9:0]      c_origin_y = 10'(ORIGIN_Y);
    localparam logic [9:0]      c_max_x    = 10'(MAX_X);
    localparam logic [9:0]      c_max_y    = 10'(MAX_Y);

    ps2_state_t        r_state,    w_state_nxt;
    logic [2:0]        r_skip_cnt, w_skip_nxt;
    logic [c_to_w-1:0] r_to_cnt,   w_to_nxt;
    logic [7:0]        r_ascii,    w_ascii_nxt;
    logic [9:0]        r_cur_x,    w_x_nxt;
    logic [9:0]        r_cur_y,    w_y_nxt;
    logic              r_key_evt,  w_evt_nxt;

    logic       w_is_digit, w_is_arrow, w_is_esc;
    logic [3:0] w_digit;
    dir_t       w_dir;

    ps2_scan_decode u_decode (
        .i_ext      (r_state == ST_EXT),
        .i_code     (scan.iscan_code),
        .o_is_digit (w_is_digit),
        .o_digit    (w_digit),
        .o_is_arrow (w_is_arrow),
        .o_dir      (w_dir),
        .o_is_esc   (w_is_esc)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
            r_to_cnt   <= '0;
            r_ascii    <= '0;
            r_cur_x    <= c_origin_x;
            r_cur_y    <= c_origin_y;
            r_key_evt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
            r_to_cnt   <= w_to_nxt;
            r_ascii    <= w_ascii_nxt;
            r_cur_x    <= w_x_nxt;
            r_cur_y    <= w_y_nxt;
            r_key_evt  <= w_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_to_nxt    = r_to_cnt;
        w_ascii_nxt = r_ascii;
        w_x_nxt     = r_cur_x;
        w_y_nxt     = r_cur_y;
        w_evt_nxt   = 1'b0;
        if (scan.iscan_valid) begin
            w_to_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    case (scan.iscan_code)
                        c_sc_e0: w_state_nxt = ST_EXT;
                        c_sc_f0: w_state_nxt = ST_BRK;
                        c_sc_e1: begin
                            w_state_nxt = ST_SKIP;
                            w_skip_nxt  = c_pause_len;
                        end
                        c_sc_ack, c_sc_resend, c_sc_bat, c_sc_echo: ;
                        default: begin
                            if (w_is_digit) begin
                                w_ascii_nxt = {4'd0, w_digit};
                                w_evt_nxt   = 1'b1;
                            end else if (w_is_esc) begin
                                w_ascii_nxt = '0;
                                w_x_nxt     = c_origin_x;
                                w_y_nxt     = c_origin_y;
                                w_evt_nxt   = 1'b1;
                            end
                        end
                    endcase
                end
                ST_EXT: begin
                    w_state_nxt = ST_IDLE;
                    if (w_is_arrow) begin
                        w_evt_nxt = 1'b1;
                        // Wrap is decided by comparison so no 10-bit overflow is ever relied on.
                        case (w_dir)
                            DIR_UP:    w_y_nxt = (r_cur_y <= c_origin_y) ? c_max_y : r_cur_y - c_cell_h;
                            DIR_DOWN:  w_y_nxt = (r_cur_y >= c_max_y) ? c_origin_y : r_cur_y + c_cell_h;
                            DIR_LEFT:  w_x_nxt = (r_cur_x <= c_origin_x) ? c_max_x : r_cur_x - c_cell_w;
                            DIR_RIGHT: w_x_nxt = (r_cur_x >= c_max_x) ? c_origin_x : r_cur_x + c_cell_w;
                            default:   ;
                        endcase
                    end else if (scan.iscan_code == c_sc_f0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (scan.iscan_code == c_sc_e0) begin
                        w_state_nxt = ST_EXT;
                    end
                end
                ST_BRK, ST_EXT_BRK: w_state_nxt = ST_IDLE;
                ST_SKIP: begin
                    w_skip_nxt = r_skip_cnt - 3'd1;
                    if (r_skip_cnt <= 3'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_skip_nxt  = '0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE) begin
            if (r_to_cnt >= c_to_last) begin
                w_state_nxt = ST_IDLE;
                w_to_nxt    = '0;
                w_skip_nxt  = '0;
            end else begin
                w_to_nxt = r_to_cnt + 1'b1;
            end
        end
    end

    assign oascii   = r_ascii;
    assign ocur_x   = r_cur_x;
    assign ocur_y   = r_cur_y;
    assign okey_evt = r_key_evt;

endmodule
`default_nettype wire

// File: tb/tb_ps2_digit_cursor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_digit_cursor_ctrl
//  Description : Scoreboard bench for the PS/2 digit/cursor controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_digit_cursor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] oascii;
    logic [9:0] ocur_x, ocur_y;
    logic       okey_evt;

    int n_cmp = 0;
    int n_err = 0;
    logic [27:0] sb[$];

    ps2_digit_cursor_ctrl_if scan_if ();

    ps2_digit_cursor_ctrl #(.TIMEOUT_CYC(16)) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .scan     (scan_if.slave),
        .oascii   (oascii),
        .ocur_x   (ocur_x),
        .ocur_y   (ocur_y),
        .okey_evt (okey_evt)
    );

    always #5 clk = ~clk;

    // Every key event is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && okey_evt) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_evt: got ascii=%0d x=%0d y=%0d, required no event", oascii, ocur_x, ocur_y);
            end else begin
                logic [27:0] e;
                e = sb.pop_front();
                if ({oascii, ocur_x, ocur_y} !== e) begin
                    n_err++;
                    $display("FAIL key_evt: got ascii=%0d x=%0d y=%0d, required ascii=%0d x=%0d y=%0d",
                             oascii, ocur_x, ocur_y, e[27:20], e[19:10], e[9:0]);
                end
            end
        end
    end

    task automatic push(input int a, input int x, input int y);
        sb.push_back({8'(a), 10'(x), 10'(y)});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_if.iscan_code  = b;
        scan_if.iscan_valid = 1'b1;
        @(posedge clk);
        #1 scan_if.iscan_valid = 1'b0;
    endtask

    task automatic test_reset;
        scan_if.iscan_code  = 8'h00;
        scan_if.iscan_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({oascii, ocur_x, ocur_y, okey_evt} !== 29'd0) begin
            n_err++;
            $display("FAIL reset_state: got ascii=%0d x=%0d y=%0d evt=%0b, required 0/0/0/0", oascii, ocur_x, ocur_y, okey_evt);
        end
        rst = 1'b0;
    endtask

    task automatic test_digit;
        send(8'h26); push(3, 0, 0);
        send(8'hF0); send(8'h26);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (oascii !== 8'd3 || sb.size() != 0) begin
            n_err++;
            $display("FAIL digit_break: got ascii=%0d pending=%0d, required ascii=3 pending=0", oascii, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        send(8'h45); push(0, 0, 0);
        send(8'h46); push(9, 0, 0);
        send(8'h7D); push(9, 0, 0);
        send(8'h70); push(0, 0, 0);
        send(8'h1E); push(2, 0, 0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL back_to_back: got pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_move_right;
        for (int i = 1; i <= 4; i++) begin
            send(8'hE0); send(8'h74); push(2, 40 * i, 0);
        end
        send(8'hE0); send(8'hF0); send(8'h74);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ocur_x !== 10'd160 || sb.size() != 0) begin
            n_err++;
            $display("FAIL move_right: got x=%0d pending=%0d, required x=160 pending=0", ocur_x, sb.size());
        end
    endtask

    task automatic test_wrap;
        send(8'h76); push(0, 0, 0);
        send(8'hE0); send(8'h6B); push(0, 600, 0);
        send(8'hE0); send(8'h75); push(0, 600, 440);
        send(8'hE0); send(8'h72); push(0, 600, 0);
        send(8'hE0); send(8'h75); push(0, 600, 440);
        send(8'hE0); send(8'h74); push(0, 0, 440);
        send(8'h76); push(0, 0, 0);
        send(8'hE0); send(8'hE0); send(8'h74); push(0, 40, 0);
        send(8'hE0); send(8'h1C); send(8'h74); push(6, 40, 0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL wrap: got pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_keypad_pause;
        send(8'h7A); push(3, 40, 0);
        send(8'h74); push(6, 40, 0);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h16); push(1, 40, 0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (oascii !== 8'd1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL pause_skip: got ascii=%0d pending=%0d, required ascii=1 pending=0", oascii, sb.size());
        end
    endtask

    task automatic test_ignored;
        send(8'hFA); send(8'hFE); send(8'hAA); send(8'hEE); send(8'h1C);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({oascii, ocur_x, ocur_y} !== {8'd1, 10'd40, 10'd0}) begin
            n_err++;
            $display("FAIL ignored_bytes: got ascii=%0d x=%0d y=%0d, required 1/40/0", oascii, ocur_x, ocur_y);
        end
    endtask

    task automatic test_timeout;
        send(8'hE0);
        repeat (16) @(posedge clk);
        send(8'h75); push(8, 40, 0);
        send(8'hE0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        send(8'h75); push(8, 0, 0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({oascii, ocur_x, ocur_y} !== {8'd8, 10'd0, 10'd0} || sb.size() != 0) begin
            n_err++;
            $display("FAIL timeout_reset: got ascii=%0d x=%0d y=%0d pending=%0d, required 8/0/0 pending=0",
                     oascii, ocur_x, ocur_y, sb.size());
        end
    endtask

    task automatic test_async_reset;
        send(8'h26); push(3, 0, 0);
        send(8'hE0); send(8'h74); push(3, 40, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({oascii, ocur_x, ocur_y, okey_evt} !== 29'd0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL async_reset: got ascii=%0d x=%0d y=%0d evt=%0b pending=%0d, required 0/0/0/0 pending=0",
                     oascii, ocur_x, ocur_y, okey_evt, sb.size());
        end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_digit();
        test_back_to_back();
        test_move_right();
        test_wrap();
        test_keypad_pause();
        test_ignored();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
